// File: rtl/ace_line_port.sv
// ACE master port: one cache-line read or write per request, split into XDATA_WIDTH beats,
// with RACK/WACK generation and a snoop responder that answers every AC with a clean CR.
module ace_line_port #(
  parameter int XDATA_WIDTH  = 64,
  parameter int LINE_WIDTH   = 256,
  parameter int AXADDR_WIDTH = 32,
  parameter int XID_WIDTH    = 4,
  parameter int TXN_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AXADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LINE_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AXADDR_WIDTH-1:0] araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [XID_WIDTH-1:0]    arid,
  output logic [3:0]              arsnoop,
  output logic [1:0]              ardomain,
  output logic [3:0]              arcache,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [XDATA_WIDTH-1:0]  rdata,
  input  logic [3:0]              rresp,
  input  logic                    rlast,
  input  logic [XID_WIDTH-1:0]    rid,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXADDR_WIDTH-1:0] awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [XID_WIDTH-1:0]    awid,
  output logic [2:0]              awsnoop,
  output logic [1:0]              awdomain,
  output logic [3:0]              awcache,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [XDATA_WIDTH-1:0]  wdata,
  output logic [XDATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [XID_WIDTH-1:0]    bid,
  input  logic                    acvalid,
  output logic                    acready,
  input  logic [AXADDR_WIDTH-1:0] acaddr,
  input  logic [3:0]              acsnoop,
  output logic                    crvalid,
  input  logic                    crready,
  output logic [4:0]              crresp,
  output logic                    rack,
  output logic                    wack,
  output logic [2:0]              fsm_state
);

  localparam int BEATS = LINE_WIDTH / XDATA_WIDTH;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int SIZE  = $clog2(XDATA_WIDTH / 8);
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = IW + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] FULL      = CW'(BEATS);
  localparam logic [AXADDR_WIDTH-1:0] LINE_MASK = {{(AXADDR_WIDTH-OFFS){1'b1}}, {OFFS{1'b0}}};

  // Valid/ready: a transfer happens on every rising clk edge where both are high; a source
  // never withdraws valid or changes payload before ready, and no valid depends on ready.

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_ACK, S_RESP
  } state_t;

  state_t state, next_state;
  logic                           alive;
  logic                           write_q;
  logic [AXADDR_WIDTH-1:0]        addr_q;
  logic [CW-1:0]                  cnt;
  logic [BEATS-1:0][XDATA_WIDTH-1:0] line_q;
  logic                           cr_pending;
  logic [IW-1:0]                  slot;
  logic                           unused_sigs;

  assign slot      = cnt[IW-1:0];
  assign fsm_state = state;

  assign araddr   = addr_q;
  assign arlen    = 8'(BEATS - 1);
  assign arsize   = 3'(SIZE);
  assign arburst  = 2'b01;
  assign arid     = XID_WIDTH'(TXN_ID);
  assign arsnoop  = 4'b0001;
  assign ardomain = 2'b01;
  assign arcache  = 4'b0011;
  assign awaddr   = addr_q;
  assign awlen    = 8'(BEATS - 1);
  assign awsize   = 3'(SIZE);
  assign awburst  = 2'b01;
  assign awid     = XID_WIDTH'(TXN_ID);
  assign awsnoop  = 3'b000;
  assign awdomain = 2'b01;
  assign awcache  = 4'b0011;
  assign wstrb    = '1;
  assign wdata    = line_q[slot];
  assign wlast    = (state == S_W) && (cnt == LAST_BEAT);
  assign resp_rdata = line_q;

  // alive keeps every ready low while reset is asserted and for the edge it releases on.
  assign acready = alive && !cr_pending;
  assign crvalid = cr_pending;
  assign crresp  = 5'b0;

  assign unused_sigs = ^{rid, bid, rresp[3:2], rresp[0], bresp[0], acaddr, acsnoop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    rack       = 1'b0;
    wack       = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = alive;
        if (alive && req_valid) next_state = req_write ? S_AW : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) next_state = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) next_state = S_ACK;
      end
      S_AW: begin
        awvalid = 1'b1;
        if (awready) next_state = S_W;
      end
      S_W: begin
        wvalid = 1'b1;
        if (wready && cnt == LAST_BEAT) next_state = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) next_state = S_ACK;
      end
      S_ACK: begin
        rack       = !write_q;
        wack       = write_q;
        next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      cnt      <= '0;
      line_q   <= '0;
      resp_err <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        S_IDLE: begin
          if (alive && req_valid) begin
            addr_q   <= req_addr & LINE_MASK;
            write_q  <= req_write;
            resp_err <= 1'b0;
            cnt      <= '0;
            if (req_write) line_q <= req_wdata;
          end
        end
        S_R: begin
          if (rvalid) begin
            // Surplus beats of an over-long burst are dropped; cnt saturates at FULL.
            if (cnt != FULL) begin
              line_q[slot] <= rdata;
              cnt          <= cnt + 1'b1;
            end
            if (rresp[1] || (rlast && cnt != LAST_BEAT) || (!rlast && cnt >= LAST_BEAT))
              resp_err <= 1'b1;
          end
        end
        S_W: begin
          if (wready) cnt <= cnt + 1'b1;
        end
        S_B: begin
          if (bvalid && bresp[1]) resp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cr_pending <= 1'b0;
    else if (acvalid && acready) cr_pending <= 1'b1;
    else if (crready)            cr_pending <= 1'b0;
  end

endmodule
